counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8, bit width of count.
REQ-002 Parameter MAX, default 100, upper count limit (WIDTH bits); constraint MIN < MAX <= 2^WIDTH-1.
REQ-003 Parameter MIN, default 10, lower count limit (WIDTH bits).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 en  input  1  count enable; high = count by step each cycle.
REQ-007 set  input  1  synchronous load of din into count.
REQ-008 din  input  4  load value, zero-extended to WIDTH.
REQ-009 step  input  4  increment/decrement amount, unsigned.
REQ-010 up_down  input  1  direction; 1 = up, 0 = down.
REQ-011 count  output  WIDTH  current counter value, registered.
REQ-012 finish  output  1  high when count is at a limit.

Function
REQ-013 Priority per rising edge: set > en > hold.
REQ-014 set=1: count <= {zero-extend din} next edge, regardless of en, up_down, step, or whether din lies inside [MIN,MAX].
REQ-015 set=0, en=0: count holds.
REQ-016 set=0, en=1, up_down=1: count <= count+step if count+step < MAX, else MAX (saturate; no wrap).
REQ-017 set=0, en=1, up_down=0: count <= count-step if count >= MIN+step, else MIN (saturate; no wrap).
REQ-018 Comparisons in REQ-016/017 use WIDTH+1-bit arithmetic; no overflow/underflow wrap possible.
REQ-019 step=0 with en=1: count holds.
REQ-020 Latency: one clock from input sample to count update; up_down/step changes take effect on the next edge.
REQ-021 finish is combinational from count: finish = (count==MAX) or (count==MIN); no latency versus count.
REQ-022 When count is at MAX and counting up, or at MIN and counting down, count holds and finish stays high.
REQ-023 count below MIN (e.g. after reset or load) counting down goes to MIN on the next enabled edge; count above MAX counting up goes to MAX on the next enabled edge.

Reset
REQ-024 rst=0 asynchronously forces count=0 immediately, independent of clk, and holds it while rst=0.
REQ-025 During reset finish=0, since count=0 and MIN>0 by default; if MIN=0, finish follows REQ-021.
REQ-026 Reset asserted mid-count aborts counting immediately.
REQ-027 First update after reset release occurs on the first rising edge at which rst=1.

Verification
REQ-028 Reset, release; en=1, set=0, up_down=1, step=1, 20 edges -> count=20, finish=0.
REQ-029 Reset, release; en=0, set=0, 20 edges -> count=0 throughout.
REQ-030 Reset, release; set=1, din=10, en=1, 20 edges -> count=10, finish=1 with MIN=10.
REQ-031 Reset, release; en=1, up_down=1, step=1, 18 edges, sample count=18; 1 more edge -> count=19.
REQ-032 From count=50: up_down=0, step=3, one edge -> 47. From count=12: step=5, one edge -> count=10, finish=1.
REQ-033 Reset, release; en=1, up_down=1, step=1, 101 edges -> count=100, finish=1; further edges hold at 100. Assert rst=0 between edges -> count=0 before the next edge.

Source files
------------

// File: rtl/counter.sv
// Up/down counter with saturating limits [MIN,MAX], synchronous load and
// a combinational at-limit flag.
module counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 100,
    parameter int unsigned MIN   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             set,
    input  logic [3:0]       din,
    input  logic [3:0]       step,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             finish
);

    // One guard bit so sum and limit comparisons can never wrap.
    localparam int unsigned XW = WIDTH + 1;

    localparam logic [XW-1:0]    MAX_X = XW'(MAX);
    localparam logic [XW-1:0]    MIN_X = XW'(MIN);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);

    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    floor_x;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] count_next;

    assign cnt_x   = XW'(count);
    assign step_x  = XW'(step);
    assign sum_x   = cnt_x + step_x;
    assign floor_x = MIN_X + step_x;
    assign diff_w  = count - WIDTH'(step);

    // Next-count selection: load beats count beats hold; both directions saturate.
    always_comb begin
        count_next = count;
        if (set) begin
            count_next = WIDTH'(din);
        end else if (en && (step != 4'd0)) begin
            if (up_down) begin
                if (sum_x < MAX_X) count_next = WIDTH'(sum_x);
                else               count_next = MAX_W;
            end else begin
                if (cnt_x >= floor_x) count_next = diff_w;
                else                  count_next = MIN_W;
            end
        end
    end

    // Count register; reset clears it immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else      count <= count_next;
    end

    // At-limit flag decoded straight from the count register.
    always_comb begin
        finish = (count == MAX_W) || (count == MIN_W);
    end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter with default parameters (WIDTH=8, MAX=100, MIN=10).
module tb_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       set;
    logic [3:0] din;
    logic [3:0] step;
    logic       up_down;
    logic [7:0] count;
    logic       finish;

    int errors = 0;
    int checks = 0;

    counter #(.WIDTH(8), .MAX(100), .MIN(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .set     (set),
        .din     (din),
        .step    (step),
        .up_down (up_down),
        .count   (count),
        .finish  (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; leaves the bench 1ns after a posedge + pulse.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic load(input logic [3:0] v);
        set = 1'b1; din = v;
        tick(1);
        set = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; set = 1'b0; din = 4'd0; step = 4'd0; up_down = 1'b1;
        #3;
        check("reset_count", 32'(count), 32'd0);
        check("reset_finish", 32'(finish), 32'd0);
        tick(1);
        check("reset_hold_on_edge", 32'(count), 32'd0);
        do_reset();

        // Count up by 1.
        en = 1'b1; up_down = 1'b1; step = 4'd1;
        tick(18);
        check("up_18", 32'(count), 32'd18);
        tick(1);
        check("up_19", 32'(count), 32'd19);
        tick(1);
        check("up_20", 32'(count), 32'd20);
        check("up_20_finish", 32'(finish), 32'd0);

        // Async reset mid-count, no clock edge.
        #2; rst = 1'b0; #1;
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_finish", 32'(finish), 32'd0);
        tick(1);
        check("reset_held", 32'(count), 32'd0);
        rst = 1'b1;

        // Enable low holds.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(5);
            check("hold_en0", 32'(count), 32'd0);
        end

        // Load repeatedly with en high.
        set = 1'b1; din = 4'd10; en = 1'b1;
        tick(20);
        set = 1'b0;
        check("load_10", 32'(count), 32'd10);
        check("load_10_finish", 32'(finish), 32'd1);

        // Load overrides count.
        set = 1'b1; din = 4'd7; up_down = 1'b1; step = 4'd15;
        tick(1);
        set = 1'b0;
        check("set_priority", 32'(count), 32'd7);

        // Reach 50: 15 + 7*5.
        load(4'd15);
        en = 1'b1; up_down = 1'b1; step = 4'd5;
        tick(7);
        check("up_to_50", 32'(count), 32'd50);
        up_down = 1'b0; step = 4'd3;
        tick(1);
        check("down_47", 32'(count), 32'd47);
        check("down_47_finish", 32'(finish), 32'd0);

        // Down saturation at MIN.
        load(4'd12);
        step = 4'd5; up_down = 1'b0;
        tick(1);
        check("down_sat_min", 32'(count), 32'd10);
        check("down_sat_finish", 32'(finish), 32'd1);
        tick(1);
        check("min_hold", 32'(count), 32'd10);

        // Below MIN counting down snaps to MIN.
        en = 1'b0;
        load(4'd3);
        check("below_min_finish", 32'(finish), 32'd0);
        en = 1'b1; step = 4'd2; up_down = 1'b0;
        tick(1);
        check("below_min_to_min", 32'(count), 32'd10);

        // Step zero holds.
        step = 4'd0; up_down = 1'b1;
        tick(3);
        check("step0_hold", 32'(count), 32'd10);

        // Full run to MAX.
        do_reset();
        en = 1'b1; up_down = 1'b1; step = 4'd1;
        tick(99);
        check("up_99", 32'(count), 32'd99);
        check("up_99_finish", 32'(finish), 32'd0);
        tick(2);
        check("up_max", 32'(count), 32'd100);
        check("up_max_finish", 32'(finish), 32'd1);
        tick(5);
        check("max_hold", 32'(count), 32'd100);
        step = 4'd15;
        tick(1);
        check("max_hold_step15", 32'(count), 32'd100);

        // Up saturation from 90 with step 15.
        up_down = 1'b0; step = 4'd10;
        tick(1);
        check("down_90", 32'(count), 32'd90);
        check("down_90_finish", 32'(finish), 32'd0);
        up_down = 1'b1; step = 4'd15;
        tick(1);
        check("up_sat_max", 32'(count), 32'd100);

        // Reset between edges clears before the next edge.
        #2; rst = 1'b0; #1;
        check("reset_from_max", 32'(count), 32'd0);
        check("reset_from_max_finish", 32'(finish), 32'd0);
        rst = 1'b1;
        tick(1);
        check("first_edge_after_release", 32'(count), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
